// File: rtl/csa_operand_packer.sv
// Packs a stream of W-bit operands into N-lane frames, with early close on in_last.
// An assembly stage feeds an output register, and a completed frame can be parked in the assembly stage.
module csa_operand_packer #(
   parameter int N = 5,
   parameter int W = 4,
   localparam int CW = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W*N-1:0] out_data,
   output logic [CW-1:0]  out_count
);

   localparam int CNTW = (N > 1) ? $clog2(N) : 1;

   logic [CNTW-1:0]  cnt;
   logic [W*N-1:0]   asm_data;
   logic             asm_full;
   logic [CW-1:0]    held_count;

   logic [W*N-1:0]   asm_written;
   logic [W*N-1:0]   load_src;
   logic [W*N-1:0]   load_frame;
   logic [CW-1:0]    load_count;
   logic             accept;
   logic             complete;
   logic             out_free;
   logic             load_out;

   assign in_ready   = !asm_full;
   assign accept     = in_valid && !asm_full;
   assign complete   = accept && ((cnt == CNTW'(N - 1)) || in_last);
   assign out_free   = !out_valid || out_ready;
   assign load_out   = out_free && (asm_full || complete);
   assign load_src   = asm_full ? asm_data : asm_written;
   assign load_count = asm_full ? held_count : (CW'(cnt) + CW'(1));

   // Stale lanes from an earlier, longer frame are masked by the frame count on the way out.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign asm_written[gi*W +: W] = (accept && (cnt == CNTW'(gi))) ? in_data
                                                                     : asm_data[gi*W +: W];
      assign load_frame[gi*W +: W]  = (CW'(gi) < load_count) ? load_src[gi*W +: W]
                                                             : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         asm_data   <= '0;
         asm_full   <= 1'b0;
         held_count <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_count  <= '0;
      end else begin
         asm_data <= asm_written;
         if (accept) begin
            cnt <= complete ? '0 : cnt + CNTW'(1);
         end

         if (load_out) begin
            out_data  <= load_frame;
            out_count <= load_count;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (asm_full && out_free) begin
            asm_full <= 1'b0;
         end else if (complete && !out_free) begin
            asm_full   <= 1'b1;
            held_count <= load_count;
         end
      end
   end

endmodule

// File: doc/csa_operand_packer.md
CSA_OPERAND_PACKER -- requirements
Module: csa_operand_packer

Interface
REQ-001 Parameter N, default 5: operands per packed frame, N >= 1.
REQ-002 Parameter W, default 4: operand width in bits, W >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data/in_last hold a valid operand.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  W  operand value, unsigned.
REQ-008 in_last  input  1  operand closes the current frame early.
REQ-009 out_valid  output  1  out_data/out_count hold a complete frame.
REQ-010 out_ready  input  1  downstream takes the frame this cycle.
REQ-011 out_data  output  W*N  packed frame; operand k at bits [k*W +: W].
REQ-012 out_count  output  clog2(N+1)  number of real operands in the frame, 1..N.

Function
REQ-013 Beat accepted on input only when in_valid && in_ready at a rising edge; out frame consumed only when out_valid && out_ready at a rising edge.
REQ-014 Two stages: assembly register (asm_data, lane counter cnt 0..N-1, asm_full flag) and output register (out_data, out_count, out_valid).
REQ-015 Accepted operand written to lane cnt of asm_data; cnt increments; no other lane changes.
REQ-016 Completing beat = accepted beat with cnt == N-1 or in_last == 1; frame count = cnt+1; lanes above cnt zero-filled in the frame; cnt returns to 0.
REQ-017 On a completing beat, if output register free (!out_valid, or out_valid && out_ready same edge), frame loads directly into output register: out_valid high the cycle after the completing beat (1-cycle latency).
REQ-018 On a completing beat with output register occupied and not draining, frame is held in assembly register and asm_full set.
REQ-019 in_ready = !asm_full (combinational from state only, no dependence on in_valid).
REQ-020 While asm_full, at an edge where the output register is free or draining, the held frame moves to the output register and asm_full clears; in_ready high the following cycle.
REQ-021 Simultaneous drain and load at one edge: out_valid stays high, new frame replaces old, no bubble, no loss.
REQ-022 out_data/out_count stable while out_valid && !out_ready.
REQ-023 in_last on the first operand of a frame yields out_count = 1; in_last on lane N-1 is identical to a normal full frame.
REQ-024 Throughput: one operand per cycle sustained when out_ready held high; no frames dropped or duplicated under any backpressure pattern.
REQ-025 N = 1: every accepted beat is a completing beat with out_count = 1.

Reset
REQ-026 While rst high: out_valid = 0, out_data = 0, out_count = 0, cnt = 0, asm_data = 0, asm_full = 0, in_ready = 1.
REQ-027 Reset asserted mid-frame or with frames pending discards all partial and held frames; first beat after release goes to lane 0.
REQ-028 Beats presented while rst high are not accepted.

Verification (N=5, W=4 unless stated)
REQ-029 out_ready=1, operands 1,2,3,4,5 back-to-back, in_last=0 -> one cycle after 5th beat out_valid=1, out_data=20'h54321, out_count=5.
REQ-030 Operands 7,9 with in_last on 9 -> out_data=20'h00097, out_count=2; next operand 3 lands in lane 0.
REQ-031 out_ready=0, stream 1..15 continuously -> frame 20'h54321 on output, 20'hA9876 held, in_ready=0 after 10th beat, operand 11 stalled; raise out_ready -> frames delivered in order, operands 11..15 form 20'hFEDCB, nothing lost.
REQ-032 Reset pulse after 3 operands of a frame -> all outputs zero, in_ready=1; then 1..5 -> out_data=20'h54321.
REQ-033 Random valid/ready toggling, 1000 LFSR operands with random in_last -> scoreboard matches every frame lane-by-lane and out_count; sum of lanes equals sum of the matching input operands.
REQ-034 N=1, W=8: operands 8'hA5, 8'h3C -> two frames, out_data 8'hA5 then 8'h3C, out_count=1 each.
